// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the ROM burst sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rom_seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Depth of the output buffer and the width of its occupancy counter
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    // True when one more ROM read may be launched this cycle: the words that
    // will be buffered after this edge (current occupancy, plus the read
    // landing now, minus the word leaving now) must leave a free slot for it.
    // Counting the outgoing word is what keeps the stream bubble-free.
    function automatic logic issue_room(input logic [CNT_W-1:0] count,
                                        input logic             inflight,
                                        input logic             pop);
        logic [CNT_W:0] occ;
        occ = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        return (occ < (CNT_W+1)'(FIFO_DEPTH));
    endfunction

endpackage

// File: rtl/rom_seq_fifo.sv
// Two-entry word buffer between the registered ROM and the output stream.
// Latency: a written word is visible at the head the cycle after the write.
// Backpressure: head holds while i_rd_rdy is low; writes are dropped when full.
module rom_seq_fifo
    import rom_seq_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_flush,
    input  logic             i_wr_vld,
    input  logic [DW-1:0]    i_wr_dat,
    input  logic             i_wr_last,
    input  logic             i_rd_rdy,
    output logic             o_rd_vld,
    output logic [DW-1:0]    o_rd_dat,
    output logic             o_rd_last,
    output logic [CNT_W-1:0] o_count
);

    logic [DW-1:0]    r_dat  [FIFO_DEPTH];
    logic             r_last [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_full;

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop    = i_rd_rdy & (r_count != '0);
    assign w_push   = i_wr_vld & (~w_full | w_pop);

    assign o_rd_vld  = (r_count != '0);
    assign o_rd_dat  = r_dat[r_rd_ptr];
    assign o_rd_last = r_last[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_dat[i]  <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_dat[r_wr_ptr]  <= i_wr_dat;
                r_last[r_wr_ptr] <= i_wr_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/rom_sequencer.sv
// Reads addresses 0..last_addr from a registered ROM and streams them out.
// Latency: first word valid 2 cycles after the accepting edge, then 1/cycle.
// Backpressure: m_ready low holds the head word; reads stall at 2 buffered.
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    input  logic          stop,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    state_t           r_state;
    state_t           w_next_state;

    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_last_addr;
    logic             r_inflight;
    logic             r_inflight_last;
    logic             r_done;

    logic             w_load;
    logic             w_flush;
    logic             w_done_set;
    logic             w_pop;
    logic             w_issue;
    logic             w_issue_last;

    logic             w_fifo_vld;
    logic [DW-1:0]    w_fifo_dat;
    logic             w_fifo_last;
    logic [CNT_W-1:0] w_fifo_count;

    // A word leaves the buffer on every valid/ready handshake
    assign w_pop = w_fifo_vld & m_ready;

    // Reads are launched only while running, never on the cycle being
    // aborted, and only when a buffer slot is guaranteed for the return.
    assign w_issue      = (r_state == ST_RUN) & ~stop &
                          issue_room(w_fifo_count, r_inflight, w_pop);
    assign w_issue_last = w_issue & (r_addr == r_last_addr);

    // Next-state and control decode; stop outranks everything while busy
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_flush      = 1'b1;
                end else if (w_issue_last) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_flush      = 1'b1;
                end else if (w_pop && w_fifo_last) begin
                    w_next_state = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address counter and burst bound; the counter may wrap after the final
    // read, which is harmless because issuing stops once DRAIN is entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr      <= '0;
            r_last_addr <= '0;
        end else if (w_load) begin
            r_addr      <= '0;
            r_last_addr <= last_addr;
        end else if (w_issue) begin
            r_addr      <= r_addr + AW'(1);
        end
    end

    // Track the read travelling through the ROM and the completion pulse;
    // an abort simply never launches, so the in-flight flag clears with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            r_done          <= w_done_set;
        end
    end

    rom_seq_fifo #(
        .DW (DW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_flush   (w_flush),
        .i_wr_vld  (r_inflight & ~w_flush),
        .i_wr_dat  (rom_data),
        .i_wr_last (r_inflight_last),
        .i_rd_rdy  (m_ready),
        .o_rd_vld  (w_fifo_vld),
        .o_rd_dat  (w_fifo_dat),
        .o_rd_last (w_fifo_last),
        .o_count   (w_fifo_count)
    );

    assign rom_addr = r_addr;
    assign m_data   = w_fifo_dat;
    assign m_valid  = w_fifo_vld;
    assign m_last   = w_fifo_last;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer with a registered ROM holding value = addr[3:0].
// Latency: inputs change and outputs are sampled 1 time unit after each edge.
// Backpressure: m_ready is driven randomly to exercise stalls.
module tb_rom_sequencer;

    localparam int AW     = 5;
    localparam int DW     = 4;
    localparam int BUDGET = 400;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] last_addr;
    logic          stop;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    int n_asserts;
    int n_fail;
    int n_words;

    rom_sequencer #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .last_addr (last_addr),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: one-cycle read latency, contents equal to the low address bits
    always @(posedge clk) rom_data <= rom_addr[3:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One burst against a queue model of the expected word stream.
    // stop_at > 0 aborts on that transfer; poke_start pulses start while busy.
    task automatic stream(input int last, input int rdy_pct, input int stop_at,
                          input bit poke_start, output int n_xfer);
        logic [3:0] q[$];
        bit         stalled;
        bit         stopped;
        bit         final_xfer;
        logic [3:0] held_dat;
        logic       held_last;
        for (int i = 0; i <= last; i++) q.push_back(4'(i));
        n_xfer    = 0;
        stalled   = 1'b0;
        stopped   = 1'b0;
        held_dat  = '0;
        held_last = 1'b0;
        last_addr = AW'(last);
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int c = 0; c < BUDGET; c++) begin
            m_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            if (poke_start && c == 0) begin
                start     = 1'b1;
                last_addr = AW'(9);
            end
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, held_dat);
                chk("stall_last", m_last, held_last);
            end
            final_xfer = 1'b0;
            if (m_valid && m_ready) begin
                if (q.size() > 0) begin
                    chk("data", m_data, q[0]);
                    chk("last_flag", m_last, q.size() == 1);
                    final_xfer = (q.size() == 1);
                    void'(q.pop_front());
                end else begin
                    chk("extra_word", m_valid, 0);
                end
                n_xfer++;
                if (stop_at > 0 && n_xfer == stop_at) begin
                    stop    = 1'b1;
                    stopped = 1'b1;
                end
            end
            stalled   = m_valid && !m_ready;
            held_dat  = m_data;
            held_last = m_last;
            tick();
            start = 1'b0;
            stop  = 1'b0;
            if (stopped) break;
            chk("done_timing", done, final_xfer);
            if (final_xfer) begin
                chk("busy_end", busy, 0);
                break;
            end
        end
        if (stopped) begin
            chk("stop_valid", m_valid, 0);
            chk("stop_busy", busy, 0);
            chk("stop_no_done", done, 0);
            tick();
            chk("stop_no_done2", done, 0);
            chk("stop_valid2", m_valid, 0);
        end else begin
            chk("words_left", q.size(), 0);
        end
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        last_addr = '0;
        m_ready   = 1'b0;

        // Reset state
        #12;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Directed burst 0..7 with m_ready high: latency, back-to-back words, done
        m_ready   = 1'b1;
        last_addr = AW'(7);
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_lat0", m_valid, 0);
        tick();
        chk("t1_lat1", m_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("t1_valid", m_valid, 1);
            chk("t1_data", m_data, k);
            chk("t1_last", m_last, k == 7);
            chk("t1_no_done", done, 0);
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_valid_low", m_valid, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // Full ROM with random backpressure: 0..15,0..15
        stream(31, 50, 0, 1'b0, n_words);
        chk("t2_count", n_words, 32);
        repeat (2) tick();

        // Single-word burst with start pulsed while busy
        stream(0, 100, 0, 1'b1, n_words);
        chk("t3_count", n_words, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3_idle_valid", m_valid, 0);
            chk("t3_idle_busy", busy, 0);
        end

        // Abort at the 5th transfer, then restart from address 0
        stream(20, 100, 5, 1'b0, n_words);
        chk("t4_count", n_words, 5);
        stream(3, 70, 0, 1'b0, n_words);
        chk("t4_restart_count", n_words, 4);
        tick();

        // Reset mid-burst with the buffer full and the consumer stalled
        m_ready   = 1'b0;
        last_addr = AW'(31);
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("t5_full_valid", m_valid, 1);
        chk("t5_full_busy", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_rom_addr", rom_addr, 0);
        chk("t5_rst_m_data", m_data, 0);
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_m_last", m_last, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        repeat (2) tick();
        rstn    = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_post_valid", m_valid, 0);
            chk("t5_post_busy", busy, 0);
        end
        stream(2, 60, 0, 1'b0, n_words);
        chk("t5_new_count", n_words, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 Parameter AW, default 5, ROM address width in bits.
REQ-002 Parameter DW, default 4, ROM data width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; ignored while busy=1.
REQ-006 last_addr  input  AW  final address of the burst; sampled only on an accepted start.
REQ-007 stop  input  1  abort of the current burst; ignored when idle.
REQ-008 rom_addr  output  AW  registered address to the ROM; the ROM returns data one clock later.
REQ-009 rom_data  input  DW  registered ROM output; valid the cycle after rom_addr was sampled.
REQ-010 m_data  output  DW  stream data to the downstream consumer.
REQ-011 m_valid  output  1  m_data holds a word.
REQ-012 m_ready  input  1  downstream accepts; transfer when m_valid and m_ready are both high on a clock edge.
REQ-013 m_last  output  1  high with the word read from last_addr.
REQ-014 busy  output  1  high from the edge accepting start until the burst ends.
REQ-015 done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 States SHALL be IDLE, RUN and DRAIN; only IDLE accepts start.
REQ-017 IDLE->RUN on start: the address counter loads 0, last_addr is latched, and busy rises.
REQ-018 In RUN, one ROM read SHALL issue per cycle while buffered words plus the in-flight read total less than 2.
REQ-019 Each issued read SHALL increment rom_addr by 1; the read at the latched last_addr is the final issue, and the FSM then moves RUN->DRAIN.
REQ-020 Returning rom_data SHALL be written into a 2-entry FIFO one cycle after issue; the FIFO head drives m_data/m_valid/m_last.
REQ-021 First-word latency: m_valid SHALL rise 2 cycles after the edge that accepted start.
REQ-022 With m_ready held high, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-023 Under m_ready=0, m_data/m_last SHALL stay stable and m_valid SHALL stay high; no word is lost or duplicated; issue stalls at occupancy 2.
REQ-024 Words SHALL appear in address order 0..last_addr, exactly last_addr+1 words.
REQ-025 last_addr = 2^AW-1 SHALL read the full ROM; address-counter wrap SHALL NOT cause extra or missing reads.
REQ-026 last_addr = 0 SHALL yield a single word, with m_last=1.
REQ-027 DRAIN->IDLE on the m_last transfer; done pulses on the following cycle, when busy falls.
REQ-028 stop in RUN/DRAIN: next cycle SHALL be IDLE with the FIFO flushed, the in-flight read discarded, m_valid=0, busy=0, and no done pulse.
REQ-029 stop and start in the same cycle while busy: stop wins, and start is ignored.
REQ-030 Simultaneous FIFO write and read at occupancy 2 cannot occur (REQ-018); at occupancy 1 both SHALL proceed.

Reset
REQ-031 rstn low SHALL immediately force IDLE, rom_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, with the FIFO empty and the in-flight flag cleared.
REQ-032 Reset mid-burst SHALL abandon the burst; after release, no word is emitted until a new start.

Structure
REQ-033 State encodings and FIFO depth constant (2) SHALL reside in a shared package/include, rom_seq_pkg.
REQ-034 The 2-entry buffer SHALL be a separate sub-module, rom_seq_fifo, with data and last-flag fields.
REQ-035 ROM interface timing SHALL match the team's registered ROM (AW=5, DW=4, one-cycle read latency).

Verification
REQ-036 ROM holds value = addr[3:0]; start with last_addr=7 and m_ready=1 -> m_valid rises 2 cycles after start, data 0..7 on consecutive cycles, m_last with 7, done one cycle after that transfer.
REQ-037 last_addr=31, m_ready toggled 1/0 randomly -> exactly 32 words, in order 0..15,0..15, none duplicated, m_data stable while stalled.
REQ-038 last_addr=0 -> single word 0 with m_last=1, then done; start pulsed during busy -> ignored.
REQ-039 last_addr=20, stop asserted at the 5th transfer -> IDLE next cycle, m_valid=0, no done; a new start then restarts from address 0.
REQ-040 rstn pulled low mid-burst with m_ready=0 and FIFO full -> all outputs are at reset values immediately and stay there after release until start.
